// File: rtl/huffman_code_gen.sv
// Iterative Huffman code generator: loads N weights, runs N-1 sort/merge rounds
// through a descending sorter, then streams one {char, code, len} beat per symbol.
module huffman_sort_ip #(
  parameter int IP_WIDTH = 8,
  parameter int WW       = 5
) (
  input  logic [IP_WIDTH-1:0][3:0]    id_i,
  input  logic [IP_WIDTH-1:0][WW-1:0] w_i,
  output logic [IP_WIDTH-1:0][3:0]    id_o,
  output logic [IP_WIDTH-1:0][WW-1:0] w_o
);
  logic [3:0] pos;

  // Rank sort: descending weight, larger id first on ties, slot index breaks exact duplicates.
  always_comb begin
    id_o = '0;
    w_o  = '0;
    pos  = '0;
    for (int i = 0; i < IP_WIDTH; i++) begin
      pos = '0;
      for (int j = 0; j < IP_WIDTH; j++) begin
        if (j != i) begin
          if ((w_i[j] > w_i[i]) ||
              ((w_i[j] == w_i[i]) && ((id_i[j] > id_i[i]) || ((id_i[j] == id_i[i]) && (j < i)))))
            pos = pos + 4'd1;
        end
      end
      id_o[pos[2:0]] = id_i[i];
      w_o[pos[2:0]]  = w_i[i];
    end
  end
endmodule

module huffman_code_gen #(
  parameter int N  = 8,
  parameter int WW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [WW-1:0] in_weight,
  output logic          busy,
  output logic          out_valid,
  output logic [2:0]    out_char,
  output logic [N-2:0]  out_code,
  output logic [2:0]    out_len
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SORT, S_MERGE, S_OUT} state_t;

  localparam logic [2:0] LAST  = 3'(N - 1);
  localparam logic [2:0] KLAST = 3'(N - 2);

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [N-1:0][3:0]       id_q, id_d;
  logic [N-1:0][WW-1:0]    w_q, w_d;
  logic [N-2:0][N-1:0]     mask_q, mask_d;
  logic [N-1:0][N-2:0]     code_q, code_d;
  logic [N-1:0][2:0]       len_q, len_d;
  logic                    busy_q, busy_d;
  logic                    out_valid_q, out_valid_d;
  logic [2:0]              out_char_q, out_char_d;
  logic [N-2:0]            out_code_q, out_code_d;
  logic [2:0]              out_len_q, out_len_d;

  logic [N-1:0][3:0]       srt_id;
  logic [N-1:0][WW-1:0]    srt_w;
  logic [N-1:0]            ma, mb;
  logic [2:0]              nxt;

  huffman_sort_ip #(.IP_WIDTH(N), .WW(WW)) u_sort (
    .id_i (id_q),
    .w_i  (w_q),
    .id_o (srt_id),
    .w_o  (srt_w)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    w_d         = w_q;
    mask_d      = mask_q;
    code_d      = code_q;
    len_d       = len_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    out_code_d  = out_code_q;
    out_len_d   = out_len_q;
    nxt         = cnt_q + 3'd1;
    // Leaf sets of the two lowest entries: leaves map to their own bit, merged nodes to their table mask.
    ma = id_q[N-2][3] ? mask_q[id_q[N-2][2:0]] : (N'(1) << id_q[N-2][2:0]);
    mb = id_q[N-1][3] ? mask_q[id_q[N-1][2:0]] : (N'(1) << id_q[N-1][2:0]);

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          id_d[0] = 4'd0;
          w_d[0]  = in_weight;
          code_d  = '0;
          len_d   = '0;
          cnt_d   = 3'd1;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          id_d[cnt_q] = {1'b0, cnt_q};
          w_d[cnt_q]  = in_weight;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_SORT;
          end else begin
            cnt_d = nxt;
          end
        end
      end
      S_SORT: begin
        id_d    = srt_id;
        w_d     = srt_w;
        state_d = S_MERGE;
      end
      S_MERGE: begin
        mask_d[cnt_q] = ma | mb;
        id_d[N-2]     = {1'b1, cnt_q};
        w_d[N-2]      = w_q[N-2] + w_q[N-1];
        id_d[N-1]     = 4'hF;
        w_d[N-1]      = '1;
        for (int s = 0; s < N; s++) begin
          if (ma[s]) len_d[s] = len_q[s] + 3'd1;
          if (mb[s]) begin
            code_d[s][len_q[s]] = 1'b1;
            len_d[s]            = len_q[s] + 3'd1;
          end
        end
        if (cnt_q == KLAST) begin
          cnt_d       = '0;
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_char_d  = '0;
          out_code_d  = code_d[0];
          out_len_d   = len_d[0];
        end else begin
          cnt_d   = nxt;
          state_d = S_SORT;
        end
      end
      S_OUT: begin
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          out_valid_d = 1'b0;
          out_char_d  = '0;
          out_code_d  = '0;
          out_len_d   = '0;
        end else begin
          cnt_d      = nxt;
          out_char_d = nxt;
          out_code_d = code_q[nxt];
          out_len_d  = len_q[nxt];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      id_q        <= '0;
      w_q         <= '0;
      mask_q      <= '0;
      code_q      <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_code_q  <= '0;
      out_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      w_q         <= w_d;
      mask_q      <= mask_d;
      code_q      <= code_d;
      len_q       <= len_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_code_q  <= out_code_d;
      out_len_q   <= out_len_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_code  = out_code_q;
  assign out_len   = out_len_q;
endmodule

// File: tb/tb_huffman_code_gen.sv
// Scoreboard bench for huffman_code_gen: directed jobs with known code tables plus
// random jobs checked against a list-based Huffman reference model.
module tb_huffman_code_gen;
  localparam int N  = 8;
  localparam int WW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [WW-1:0] in_weight;
  logic          busy;
  logic          out_valid;
  logic [2:0]    out_char;
  logic [N-2:0]  out_code;
  logic [2:0]    out_len;

  huffman_code_gen #(.N(N), .WW(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_weight (in_weight),
    .busy      (busy),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_code  (out_code),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; int code; int len;} exp_t;
  exp_t sb[$];
  int   lat_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   in_run = 1'b0;
  int   beats = 0;
  int   jw[N];
  int   ec[N];
  int   el[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expected beat per out_valid, checks first-beat latency and run length.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (!in_run) begin
          in_run = 1'b1;
          beats = 0;
          if (lat_q.size() == 0) check("unexpected_job", 1, 0);
          else check("first_valid_cycle", cyc, lat_q.pop_front());
        end
        beats++;
        check("busy_during_out", int'(busy), 1);
        if (sb.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("out_char", int'(out_char), e.ch);
          check($sformatf("out_code[%0d]", e.ch), int'(out_code), e.code);
          check($sformatf("out_len[%0d]", e.ch), int'(out_len), e.len);
        end
      end else begin
        if (in_run) begin
          in_run = 1'b0;
          check("beat_count", beats, N);
        end
        check("idle_outputs_zero", int'(out_char) + int'(out_code) + int'(out_len), 0);
      end
    end
  end

  task automatic push_exp();
    for (int s = 0; s < N; s++) begin
      exp_t e;
      e.ch = s; e.code = ec[s]; e.len = el[s];
      sb.push_back(e);
    end
  endtask

  // Reference: repeatedly order the live list, fuse its two lightest entries, and
  // prepend a 0 (lighter-but-first) or 1 (lightest) bit to every leaf under each.
  task automatic model_job();
    int lid[N];
    int lw[N];
    int leaves[16];
    int tid, tw, a_set, b_set;
    for (int i = 0; i < N; i++) begin
      lid[i] = i; lw[i] = jw[i] % 32; leaves[i] = 1 << i; ec[i] = 0; el[i] = 0;
    end
    for (int k = 0; k < N - 1; k++) begin
      for (int p = 0; p < N; p++)
        for (int b = 0; b < N - 1; b++)
          if (lw[b] < lw[b+1] || (lw[b] == lw[b+1] && lid[b] < lid[b+1])) begin
            tid = lid[b]; lid[b] = lid[b+1]; lid[b+1] = tid;
            tw = lw[b]; lw[b] = lw[b+1]; lw[b+1] = tw;
          end
      a_set = leaves[lid[N-2]];
      b_set = leaves[lid[N-1]];
      for (int s = 0; s < N; s++) begin
        if ((a_set >> s) & 1) el[s]++;
        if ((b_set >> s) & 1) begin ec[s] |= (1 << el[s]); el[s]++; end
      end
      leaves[8+k] = a_set | b_set;
      lw[N-2] = (lw[N-2] + lw[N-1]) % 32;
      lid[N-2] = 8 + k;
      lid[N-1] = 15;
      lw[N-1] = 31;
    end
    push_exp();
  endtask

  task automatic send_job(input int gap, input bit junk, input bit expect_lat);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_weight = WW'(jw[i]);
      @(posedge clk); #1;
      if (i < N - 1 && gap > 0) begin
        in_valid = 1'b0;
        in_weight = WW'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    if (expect_lat) lat_q.push_back(cyc + 14);
    if (junk) begin
      repeat (22) begin
        in_valid = 1'b1;
        in_weight = WW'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    in_weight = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || out_valid) && n < 60) begin @(posedge clk); #1; n++; end
    if (n >= 60) check("idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic set_equal();
    for (int i = 0; i < N; i++) begin jw[i] = 1; ec[i] = 7 - i; el[i] = 3; end
  endtask

  task automatic set_skewed();
    int w[N] = '{16, 8, 4, 2, 1, 0, 0, 0};
    int c[N] = '{'h00, 'h02, 'h06, 'h0E, 'h1E, 'h7D, 'h7C, 'h3F};
    int l[N] = '{1, 2, 3, 4, 5, 7, 7, 6};
    for (int i = 0; i < N; i++) begin jw[i] = w[i]; ec[i] = c[i]; el[i] = l[i]; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_weight = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_outputs", int'(out_char) + int'(out_code) + int'(out_len), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    set_equal();  push_exp(); send_job(0, 1'b0, 1'b1); wait_idle();
    set_skewed(); push_exp(); send_job(0, 1'b0, 1'b1); wait_idle();
    set_equal();  push_exp(); send_job(1, 1'b0, 1'b1); wait_idle();

    // Abort a job in merge round 3, then reload.
    for (int i = 0; i < N; i++) jw[i] = $urandom_range(0, 3);
    send_job(0, 1'b0, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_outputs", int'(out_char) + int'(out_code) + int'(out_len), 0);
    repeat (20) begin @(posedge clk); #1; end
    check("rst_stays_idle", int'(busy) + int'(out_valid), 0);
    set_equal(); push_exp(); send_job(0, 1'b0, 1'b1); wait_idle();

    set_skewed(); push_exp(); send_job(0, 1'b1, 1'b1); wait_idle();

    // Back-to-back: second job starts the cycle after the last output beat.
    for (int i = 0; i < N; i++) jw[i] = $urandom_range(0, 3);
    model_job();
    send_job(0, 1'b0, 1'b1);
    repeat (21) begin @(posedge clk); #1; end
    check("b2b_last_beat_busy", int'(busy), 1);
    check("b2b_last_beat_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    check("b2b_gap_busy", int'(busy), 0);
    set_skewed(); push_exp(); send_job(0, 1'b0, 1'b1);
    check("b2b_busy_after_load", int'(busy), 1);
    wait_idle();

    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < N; i++) jw[i] = (j == 4) ? $urandom_range(0, 31) : $urandom_range(0, 3);
      model_job();
      send_job(j % 2, 1'b0, 1'b1);
      wait_idle();
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    check("latency_drained", lat_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
